pipe_regs: RTL
==============

# pipe_regs

Parametrised, bubble-collapsing register pipeline: WIDTH-bit data moves through DEPTH valid/ready-handshaked stages, with a selectable data reset mode per instance (reset-to-constant or unreset data path). It generalises the fixed three-flop reset-style cells (reset-to-0, reset-to-1, unreset) into one reusable pipeline. It sits between producer and consumer blocks wherever registered timing slack or elastic buffering of up to DEPTH beats is needed.

## Interface
- WIDTH, 8: data width in bits, ≥1.
- DEPTH, 3: number of register stages, ≥1.
- DATA_RST, 1: 1 = data registers take RESET_DATA on reset; 0 = data registers have no reset, and only valid bits reset.
- RESET_DATA, '0: WIDTH-bit data reset value, used only when DATA_RST=1.

- i_clk  in  1  clock; all flops rising-edge.
- i_srst_n  in  1  synchronous reset, active-low.
- i_flush  in  1  synchronous clear of all stage valid bits.
- i_valid  in  1  upstream beat valid.
- i_data  in  WIDTH  upstream data.
- o_ready  out  1  pipeline accepts a beat this cycle.
- o_valid  out  1  stage DEPTH-1 holds a beat.
- o_data  out  WIDTH  stage DEPTH-1 data.
- i_ready  in  1  downstream accepts.
- o_count  out  $clog2(DEPTH+1)  occupied stages; present only with PIPE_REGS_COUNT_EN.

## Operation
- Stage k holds v[k] and d[k]. Stage 0 is fed by the input. Stage DEPTH-1 drives the output.
- acc[DEPTH-1] = !v[DEPTH-1] | i_ready. For k<DEPTH-1: acc[k] = !v[k] | acc[k+1]. This is combinational, so empty slots collapse bubbles.
- o_ready = acc[0] & !i_flush.
- On each edge, with i_srst_n=1 and i_flush=0, every stage k where acc[k]=1 loads from its predecessor:
  - v[k] gets the predecessor's valid.
  - d[k] gets the predecessor's data only when that valid is 1; otherwise d[k] holds.
  - The predecessor of stage 0 is (i_valid & o_ready, i_data).
- Stages with acc[k]=0 hold.
- Input handshake: i_valid & o_ready. Output handshake: o_valid & i_ready. Each is exactly one beat.
- Order is preserved. No beat is ever dropped or duplicated except by flush or reset.
- Flush: on the next edge all v[k]=0. d[k] holds. The input beat is not accepted in the flush cycle (o_ready=0).
- Reset (i_srst_n=0 at an edge) overrides flush and handshakes:
  - all v[k]=0;
  - d[k]=RESET_DATA if DATA_RST=1, otherwise d[k] is unchanged.
- Output reset values: o_valid=0; o_data=RESET_DATA when DATA_RST=1, undefined (X in simulation) when DATA_RST=0; o_count=0.
- o_ready after reset equals 1, because all stages are empty.

## Timing
- Latency: a beat accepted at edge n appears on o_valid/o_data after edge n+DEPTH-1 when the path is empty. That is DEPTH register stages, with the first stage loaded at edge n.
- Throughput: 1 beat per cycle while i_ready=1.
- Full: all v=1 and i_ready=0 gives o_ready=0. When i_ready=1 on a full pipeline, o_ready=1 in the same cycle, so it accepts while draining.
- Combinational paths: i_ready → o_ready through DEPTH gates; i_flush → o_ready. No other input-to-output combinational path.
- Simultaneous output pop, input push and internal bubble collapse are all resolved in one edge.

## Configuration
- PIPE_REGS_COUNT_EN defined:
  - o_count port exists. It is a registered count of set v[k] bits, reset to 0 and cleared by flush.
  - Update per edge: +1 on input handshake only, −1 on output handshake only, unchanged when both or neither occur.
  - Never exceeds DEPTH.
- PIPE_REGS_COUNT_EN undefined: port and counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package pipe_regs_pkg holds:
  - the count-width function (cnt_w(depth) = $clog2(depth+1));
  - a typedef for the default 8-bit beat.
- Sub-module pipe_regs_stage: one stage (v, d, acc in/out, DATA_RST handling), instantiated DEPTH times in a generate loop. The top level wires the acc chain, the flush/reset fan-out and the optional counter.

## Test plan
- Reset values: DEPTH=3, WIDTH=8, DATA_RST=1, RESET_DATA=8'hA5; hold i_srst_n=0 for 2 cycles → o_valid=0, o_data=8'hA5, o_ready=1, o_count=0.
- Latency and streaming: push 8'h01, 8'h02, 8'h03 on consecutive cycles with i_ready=1 → o_valid rises 2 edges after the first accept; outputs are 01, 02, 03 on consecutive cycles.
- Backpressure and full:
  - i_ready=0, push 4 beats → 3 beats are accepted, then o_ready=0 and o_count=3.
  - Raise i_ready → o_ready=1 in the same cycle; the 4th beat is accepted; order is preserved.
- Bubble collapse: push one beat, idle 1 cycle, push one beat, with i_ready=0 → both beats end in stages 2 and 1, and o_count=2.
- Flush with push: with 2 beats held, assert i_flush and i_valid together → o_ready=0; next cycle o_valid=0 and o_count=0; the input beat is not delivered.
- Unreset data: DATA_RST=0; load 8'h3C, drain it, then apply reset → o_valid=0 and o_data stays 8'h3C.

Source files
------------

// File: rtl/pipe_regs_pkg.sv
// Shared types and helpers for the pipe_regs elastic register pipeline.
package pipe_regs_pkg;

    typedef logic [7:0] beat_t;

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_regs_if.sv
// Valid/ready beat channel; master drives valid/data, slave drives ready.
interface pipe_regs_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_regs_stage.sv
// One pipeline slot: valid/data registers plus its link in the combinational accept chain.
module pipe_regs_stage
    import pipe_regs_pkg::*;
#(
    parameter int               WIDTH      = $bits(beat_t),
    parameter int               DATA_RST   = 1,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             i_clk,
    input  logic             i_srst_n,
    input  logic             i_flush,
    input  logic             i_acc_next,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_acc,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             v_q;
    logic             v_d;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] d_d;
    logic             load_d;

    // An empty slot always accepts, so bubbles collapse toward the output.
    assign o_acc  = !v_q | i_acc_next;
    assign load_d = o_acc & i_valid & !i_flush;

    always_comb begin
        v_d = v_q;
        if (i_flush) begin
            v_d = 1'b0;
        end else if (o_acc) begin
            v_d = i_valid;
        end
    end

    assign d_d = load_d ? i_data : d_q;

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            v_q <= 1'b0;
        end else begin
            v_q <= v_d;
        end
    end

    generate
        if (DATA_RST != 0) begin : g_data_rst
            always_ff @(posedge i_clk) begin
                if (!i_srst_n) begin
                    d_q <= RESET_DATA;
                end else begin
                    d_q <= d_d;
                end
            end
        end else begin : g_data_norst
            // Reset leaves the data register alone rather than loading it.
            always_ff @(posedge i_clk) begin
                if (i_srst_n) begin
                    d_q <= d_d;
                end
            end
        end
    endgenerate

    assign o_valid = v_q;
    assign o_data  = d_q;

endmodule

// File: rtl/pipe_regs.sv
// Bubble-collapsing DEPTH-stage valid/ready register pipeline.
// Optional occupancy counter port o_count is enabled by defining PIPE_REGS_COUNT_EN.
module pipe_regs
    import pipe_regs_pkg::*;
#(
    parameter int               WIDTH      = $bits(beat_t),
    parameter int               DEPTH      = 3,
    parameter int               DATA_RST   = 1,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                      i_clk,
    input  logic                      i_srst_n,
    input  logic                      i_flush,
    pipe_regs_if.slave                up_if,
    pipe_regs_if.master               dn_if
`ifdef PIPE_REGS_COUNT_EN
    ,
    output logic [cnt_w(DEPTH)-1:0]   o_count
`endif
);

    logic in_vld;
    logic out_hs;

    // Input side: accept only when the head slot frees up and no flush is pending.
    assign up_if.ready = g_stage[0].acc_w & !i_flush;
    assign in_vld      = up_if.valid & up_if.ready;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            logic             acc_w;
            logic             acc_nxt;
            logic             v_in;
            logic [WIDTH-1:0] d_in;
            logic             v_w;
            logic [WIDTH-1:0] d_w;

            if (k == 0) begin : g_head
                assign v_in = in_vld;
                assign d_in = up_if.data;
            end else begin : g_body
                assign v_in = g_stage[k-1].v_w;
                assign d_in = g_stage[k-1].d_w;
            end

            if (k == DEPTH - 1) begin : g_tail
                assign acc_nxt = dn_if.ready;
            end else begin : g_link
                assign acc_nxt = g_stage[k+1].acc_w;
            end

            pipe_regs_stage #(
                .WIDTH      (WIDTH),
                .DATA_RST   (DATA_RST),
                .RESET_DATA (RESET_DATA)
            ) u_stage (
                .i_clk      (i_clk),
                .i_srst_n   (i_srst_n),
                .i_flush    (i_flush),
                .i_acc_next (acc_nxt),
                .i_valid    (v_in),
                .i_data     (d_in),
                .o_acc      (acc_w),
                .o_valid    (v_w),
                .o_data     (d_w)
            );
        end
    endgenerate

    // Output side: last stage drives the downstream channel.
    assign dn_if.valid = g_stage[DEPTH-1].v_w;
    assign dn_if.data  = g_stage[DEPTH-1].d_w;
    assign out_hs      = dn_if.valid & dn_if.ready;

`ifdef PIPE_REGS_COUNT_EN
    logic [cnt_w(DEPTH)-1:0] count_q;
    logic [cnt_w(DEPTH)-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_flush) begin
            count_d = '0;
        end else if (in_vld && !out_hs) begin
            count_d = count_q + 1'b1;
        end else if (!in_vld && out_hs) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
`else
    logic unused_out_hs;
    assign unused_out_hs = out_hs;
`endif

endmodule
